// File: rtl/bin_bcd_display_feeder.sv
// -----------------------------------------------------------------------------
// bin_bcd_display_feeder
//
// Sequential binary-to-BCD converter for the 4-digit seven-segment display
// stage. Uses the shift-add-3 (double dabble) method, one input bit per clock.
// After a value is accepted it takes WIDTH shift cycles plus one commit cycle.
// The display outputs are registered and only change at commit.
//
// Parameters
//   WIDTH     binary input width, 4..14
//   BLANK_LZ  1: report leading zero digits as blanked on LEs; 0: LEs stay 0
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   in_value   binary value to convert
//   in_points  decimal points shown together with this value
//   in_valid   request; accepted on an edge where in_valid & in_ready
//   in_ready   high while idle
//   hexs       BCD digits {thousands, hundreds, tens, ones}
//   points     decimal points captured at accept, updated at commit
//   LEs        per-digit blank enable, 1 = digit blanked
//   ovf        last committed value was above 9999 (hexs shows 9999)
//   done       one-cycle pulse in the cycle after the outputs were updated
// -----------------------------------------------------------------------------
module bin_bcd_display_feeder #(
    parameter int WIDTH    = 14,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_value,
    input  logic [3:0]       in_points,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      hexs,
    output logic [3:0]       points,
    output logic [3:0]       LEs,
    output logic             ovf,
    output logic             done
);

    // Shift register layout: {bcd[15:0], binary[WIDTH-1:0]}
    localparam int SR_W  = 16 + WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [3:0] LES_RESET = BLANK_LZ ? 4'b1110 : 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [SR_W-1:0]  sr_reg;
    logic [SR_W-1:0]  sr_adj;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       points_pend_reg;
    logic             ovf_pend_reg;
    logic             in_over;

    logic             load;
    logic             shift_en;
    logic             commit;

    logic [3:0]       d3, d2, d1;
    logic [3:0]       les_calc;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift_en   = 1'b0;
        commit     = 1'b0;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt_reg == LAST_SHIFT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Add-3 correction on each BCD nibble before the shift. The adjustment is
    // confined to its own nibble; any wrap only occurs for inputs above 9999,
    // whose result is replaced by 9999 at commit anyway.
    // -------------------------------------------------------------------------
    assign sr_adj[WIDTH-1:0] = sr_reg[WIDTH-1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nibble_adj
            logic [3:0] nib;
            assign nib = sr_reg[WIDTH + 4*gi +: 4];
            assign sr_adj[WIDTH + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
    endgenerate

    // Widen before comparing so narrow WIDTH settings compare correctly
    assign in_over = ({{(32 - WIDTH){1'b0}}, in_value} > 32'd9999);

    // -------------------------------------------------------------------------
    // Conversion datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_reg          <= '0;
            cnt_reg         <= '0;
            points_pend_reg <= 4'b0000;
            ovf_pend_reg    <= 1'b0;
        end else if (load) begin
            sr_reg          <= {16'b0, in_value};
            cnt_reg         <= '0;
            points_pend_reg <= in_points;
            ovf_pend_reg    <= in_over;
        end else if (shift_en) begin
            sr_reg  <= sr_adj << 1;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero blanking; the ones digit is never blanked
    // -------------------------------------------------------------------------
    assign d3 = sr_reg[WIDTH + 12 +: 4];
    assign d2 = sr_reg[WIDTH + 8  +: 4];
    assign d1 = sr_reg[WIDTH + 4  +: 4];

    always_comb begin
        les_calc = 4'b0000;
        if (BLANK_LZ) begin
            les_calc[3] = (d3 == 4'd0);
            les_calc[2] = les_calc[3] & (d2 == 4'd0);
            les_calc[1] = les_calc[2] & (d1 == 4'd0);
            les_calc[0] = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Output registers: updated only at commit, held otherwise
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hexs   <= 16'h0000;
            points <= 4'b0000;
            LEs    <= LES_RESET;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                points <= points_pend_reg;
                if (ovf_pend_reg) begin
                    hexs <= 16'h9999;
                    LEs  <= 4'b0000;
                    ovf  <= 1'b1;
                end else begin
                    hexs <= sr_reg[SR_W-1 -: 16];
                    LEs  <= les_calc;
                    ovf  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_bcd_display_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for bin_bcd_display_feeder. Two instances share clock, reset and
// request inputs: dut uses BLANK_LZ=1, dut_nb uses BLANK_LZ=0.
// -----------------------------------------------------------------------------
module tb_bin_bcd_display_feeder;

    logic        clk;
    logic        rst;
    logic [13:0] in_value;
    logic [3:0]  in_points;
    logic        in_valid;

    logic        in_ready;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  les;
    logic        ovf;
    logic        done;

    logic        in_ready_nb;
    logic [15:0] hexs_nb;
    logic [3:0]  points_nb;
    logic [3:0]  les_nb;
    logic        ovf_nb;
    logic        done_nb;

    int tests_run    = 0;
    int tests_failed = 0;

    bin_bcd_display_feeder #(.WIDTH(14), .BLANK_LZ(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_value  (in_value),
        .in_points (in_points),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hexs      (hexs),
        .points    (points),
        .LEs       (les),
        .ovf       (ovf),
        .done      (done)
    );

    bin_bcd_display_feeder #(.WIDTH(14), .BLANK_LZ(1'b0)) dut_nb (
        .clk       (clk),
        .rst       (rst),
        .in_value  (in_value),
        .in_points (in_points),
        .in_valid  (in_valid),
        .in_ready  (in_ready_nb),
        .hexs      (hexs_nb),
        .points    (points_nb),
        .LEs       (les_nb),
        .ovf       (ovf_nb),
        .done      (done_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, drop it after the accept edge and scramble the inputs
    // to show they are no longer sampled. Returns the number of rising edges
    // from the accept edge to the commit edge (done observed after it).
    task automatic do_conv(input logic [13:0] v, input logic [3:0] p, output int lat);
        @(negedge clk);
        in_value  = v;
        in_points = p;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_value  = 14'h3fff;
        in_points = 4'hf;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done && lat < 40);
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        in_points = '0;
        #12;
        tests_run++;
        if (hexs !== 16'h0000 || les !== 4'b1110 || points !== 4'b0000 ||
            ovf !== 1'b0 || done !== 1'b0 || les_nb !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_values: hexs=%h les=%b pts=%b ovf=%b done=%b les_nb=%b, want 0000 1110 0000 0 0 0000",
                     hexs, les, points, ovf, done, les_nb);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
        $display("[TB] reset: hexs=%h LEs=%b ready=%b", hexs, les, in_ready);
    endtask

    task automatic test_basic();
        int lat;
        do_conv(14'd1234, 4'b0100, lat);
        tests_run++;
        if (lat !== 15) begin
            tests_failed++;
            $display("FAIL basic_latency: edges=%0d want 15", lat);
        end
        tests_run++;
        if (hexs !== 16'h1234 || les !== 4'b0000 || points !== 4'b0100 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_1234: hexs=%h les=%b pts=%b ovf=%b want 1234 0000 0100 0",
                     hexs, les, points, ovf);
        end
        $display("[TB] 1234: hexs=%h LEs=%b points=%b latency=%0d", hexs, les, points, lat);
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || hexs !== 16'h1234) begin
            tests_failed++;
            $display("FAIL done_pulse: done=%b hexs=%h want 0 1234", done, hexs);
        end
    endtask

    task automatic test_small();
        int lat;
        do_conv(14'd7, 4'b0000, lat);
        tests_run++;
        if (hexs !== 16'h0007 || les !== 4'b1110 || points !== 4'b0000) begin
            tests_failed++;
            $display("FAIL small_7: hexs=%h les=%b pts=%b want 0007 1110 0000", hexs, les, points);
        end
        $display("[TB] 7: hexs=%h LEs=%b", hexs, les);
        do_conv(14'd0, 4'b0001, lat);
        tests_run++;
        if (hexs !== 16'h0000 || les !== 4'b1110 || points !== 4'b0001) begin
            tests_failed++;
            $display("FAIL small_0: hexs=%h les=%b pts=%b want 0000 1110 0001", hexs, les, points);
        end
        $display("[TB] 0: hexs=%h LEs=%b", hexs, les);
        do_conv(14'd42, 4'b0000, lat);
        tests_run++;
        if (hexs !== 16'h0042 || les !== 4'b1100) begin
            tests_failed++;
            $display("FAIL small_42: hexs=%h les=%b want 0042 1100", hexs, les);
        end
        tests_run++;
        if (hexs_nb !== 16'h0042 || les_nb !== 4'b0000) begin
            tests_failed++;
            $display("FAIL nblank_42: hexs=%h les=%b want 0042 0000", hexs_nb, les_nb);
        end
        $display("[TB] 42: hexs=%h LEs=%b nb_LEs=%b", hexs, les, les_nb);
    endtask

    task automatic test_overflow();
        int lat;
        do_conv(14'd10000, 4'b1000, lat);
        tests_run++;
        if (hexs !== 16'h9999 || les !== 4'b0000 || ovf !== 1'b1 || points !== 4'b1000) begin
            tests_failed++;
            $display("FAIL ovf_10000: hexs=%h les=%b ovf=%b pts=%b want 9999 0000 1 1000",
                     hexs, les, ovf, points);
        end
        $display("[TB] 10000: hexs=%h LEs=%b ovf=%b", hexs, les, ovf);
        do_conv(14'd9999, 4'b0000, lat);
        tests_run++;
        if (hexs !== 16'h9999 || les !== 4'b0000 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_9999: hexs=%h les=%b ovf=%b want 9999 0000 0", hexs, les, ovf);
        end
        $display("[TB] 9999: hexs=%h LEs=%b ovf=%b", hexs, les, ovf);
        do_conv(14'd16383, 4'b0000, lat);
        tests_run++;
        if (hexs !== 16'h9999 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_16383: hexs=%h ovf=%b want 9999 1", hexs, ovf);
        end
        $display("[TB] 16383: hexs=%h ovf=%b", hexs, ovf);
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        in_value  = 14'd42;
        in_points = 4'b0000;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_value = 14'd55;                // request stays up while busy
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done && lat < 40);
        tests_run++;
        if (hexs !== 16'h0042 || lat !== 15) begin
            tests_failed++;
            $display("FAIL b2b_first: hexs=%h edges=%0d want 0042 15", hexs, lat);
        end
        $display("[TB] b2b first: hexs=%h latency=%0d", hexs, lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done && lat < 40);
        in_valid = 1'b0;
        tests_run++;
        if (hexs !== 16'h0055 || lat !== 16) begin
            tests_failed++;
            $display("FAIL b2b_second: hexs=%h edges=%0d want 0055 16", hexs, lat);
        end
        $display("[TB] b2b second: hexs=%h gap=%0d", hexs, lat);
        // a third accept of 55 would commit again; make sure nothing follows
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done && lat < 20);
        tests_run++;
        if (lat !== 20) begin
            tests_failed++;
            $display("FAIL b2b_no_extra: extra done after %0d edges, want none", lat);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        bit seen_done;
        @(negedge clk);
        in_value  = 14'd1234;
        in_points = 4'b0010;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seen_done = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (hexs !== 16'h0000 || les !== 4'b1110 || done !== 1'b0 || ovf !== 1'b0 ||
            points !== 4'b0000 || seen_done) begin
            tests_failed++;
            $display("FAIL midreset_state: hexs=%h les=%b done=%b ovf=%b pts=%b early_done=%0d want 0000 1110 0 0 0000 0",
                     hexs, les, done, ovf, points, seen_done);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        tests_run++;
        if (seen_done || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_abort: done_seen=%0d ready=%b want 0 1", seen_done, in_ready);
        end
        $display("[TB] mid reset: hexs=%h LEs=%b", hexs, les);
        do_conv(14'd88, 4'b0000, lat);
        tests_run++;
        if (hexs !== 16'h0088 || les !== 4'b1100 || lat !== 15) begin
            tests_failed++;
            $display("FAIL after_reset_88: hexs=%h les=%b edges=%0d want 0088 1100 15", hexs, les, lat);
        end
        $display("[TB] 88: hexs=%h LEs=%b", hexs, les);
    endtask

    task automatic test_sweep();
        int lat;
        int v;
        int dg3, dg2, dg1, dg0;
        logic [15:0] exp_hex;
        logic [3:0]  exp_les;
        v = 0;
        while (v <= 9999) begin
            dg3 = v / 1000;
            dg2 = (v / 100) % 10;
            dg1 = (v / 10) % 10;
            dg0 = v % 10;
            exp_hex = {dg3[3:0], dg2[3:0], dg1[3:0], dg0[3:0]};
            exp_les[3] = (dg3 == 0);
            exp_les[2] = exp_les[3] && (dg2 == 0);
            exp_les[1] = exp_les[2] && (dg1 == 0);
            exp_les[0] = 1'b0;
            do_conv(v[13:0], v[3:0], lat);
            tests_run++;
            if (hexs !== exp_hex || les !== exp_les || ovf !== 1'b0 || points !== v[3:0] ||
                hexs_nb !== exp_hex || les_nb !== 4'b0000 || lat !== 15) begin
                tests_failed++;
                $display("FAIL sweep_%0d: hexs=%h les=%b ovf=%b nb=%h/%b edges=%0d want %h %b 0 %h/0000 15",
                         v, hexs, les, ovf, hexs_nb, les_nb, lat, exp_hex, exp_les, exp_hex);
            end
            $display("[TB] sweep %0d: hexs=%h LEs=%b", v, hexs, les);
            if (v == 9999)
                v = 10000;
            else if (v + 97 > 9999)
                v = 9999;
            else
                v = v + 97;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
